// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one 4-bit constant comparator among NREQ requesters.
// Latency: grant in cycle N, registered result (id, match) valid in cycle N+1.
// Backpressure: while a result is held and res_ready_i is low, no grant is issued and state freezes.
module cmp_rr_sched #(
    parameter int          NREQ      = 4,
    parameter int          IDW       = 2,
    parameter logic [3:0]  CMP_CONST = 4'b0101,
    parameter int          CNTW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [4*NREQ-1:0] x_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [IDW-1:0]    res_id_o,
    output logic              res_q_o,
    output logic [CNTW-1:0]   match_cnt_o,
    output logic              busy_o
);

    logic [IDW-1:0] ptr;
    logic           accept;
    logic           found_hi;
    logic           found_lo;
    logic [IDW-1:0] idx_hi;
    logic [IDW-1:0] idx_lo;
    logic [IDW-1:0] gnt_idx;
    logic           grant_en;
    logic [3:0]     nib;
    logic           match;
    logic [IDW-1:0] ptr_next;

    // Rotating priority: lowest requester at or above ptr wins, else lowest overall.
    always_comb begin
        accept   = !res_valid_o || res_ready_i;
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                found_lo = 1'b1;
                idx_lo   = IDW'(k);
                if (IDW'(k) >= ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(k);
                end
            end
        end
        gnt_idx  = found_hi ? idx_hi : idx_lo;
        // Gating with rst_n keeps the grant low while reset is asserted.
        grant_en = rst_n && accept && (found_hi || found_lo);
    end

    // One-hot grant decode, nibble mux into the shared comparator, and pointer advance.
    always_comb begin
        gnt_o = '0;
        nib   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                gnt_o[k] = grant_en;
                nib      = x_i[4*k +: 4];
            end
        end
        match    = (nib == CMP_CONST);
        ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Result register, RR pointer and saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            res_q_o     <= 1'b0;
            match_cnt_o <= '0;
        end else if (grant_en) begin
            ptr         <= ptr_next;
            res_valid_o <= 1'b1;
            res_id_o    <= gnt_idx;
            res_q_o     <= match;
            if (match && (match_cnt_o != {CNTW{1'b1}})) begin
                match_cnt_o <= match_cnt_o + 1'b1;
            end
        end else if (res_valid_o && res_ready_i) begin
            // Consumed with nothing new: id/q keep their last values.
            res_valid_o <= 1'b0;
        end
    end

    // Activity indicator for clock gating / idle detection upstream.
    always_comb begin
        busy_o = (|req_i) || res_valid_o;
    end

endmodule
